// File: rtl/comparison_operand_loader.sv
// rtl/comparison_operand_loader.sv - operand capture and function select front-end for the 4-bit comparison unit
//
// Purpose:
//   Captures operands X and Y in turn from a shared 4-bit switch bank using
//   debounced push-buttons. Both operands are held stable, and a flag marks a
//   complete pair. A 2-bit function select (0 equal, 1 greater, 2 less,
//   3 max) is stepped for the comparison unit's output multiplexer.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   data_in[3:0]   in   raw switch value, sampled only on a load press
//   load_btn       in   raw button: capture the next operand
//   clear_btn      in   raw button: discard both operands
//   mode_btn       in   raw button: advance select
//   X[3:0]         out  registered operand X
//   Y[3:0]         out  registered operand Y
//   select[1:0]    out  registered function select
//   operands_valid out  high while the FSM is in READY
//   state_out[1:0] out  FSM state (0 LOAD_X, 1 LOAD_Y, 2 READY)

module comparison_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       load_btn,
   input  logic       clear_btn,
   input  logic       mode_btn,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic [1:0] select,
   output logic       operands_valid,
   output logic [1:0] state_out
);

   localparam logic [1:0] S_LOAD_X = 2'd0;
   localparam logic [1:0] S_LOAD_Y = 2'd1;
   localparam logic [1:0] S_READY  = 2'd2;

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // Button index: 0 load, 1 clear, 2 mode.
   logic [2:0]  btn_raw;
   logic [2:0]  sync1_q, sync1_d;
   logic [2:0]  sync2_q, sync2_d;
   logic [2:0]  deb_q, deb_d;
   logic [2:0]  deb_prev_q, deb_prev_d;
   logic [15:0] cnt_q [3];
   logic [15:0] cnt_d [3];
   logic [2:0]  pulse;

   logic        load_p;
   logic        clear_p;
   logic        mode_p;

   logic [1:0]  state_q, state_d;
   logic [3:0]  x_q, x_d;
   logic [3:0]  y_q, y_d;
   logic [1:0]  select_q, select_d;
   logic        valid_q, valid_d;

   assign btn_raw = {mode_btn, clear_btn, load_btn};

   // Button conditioning: two-flop synchroniser, then a level debouncer.
   // The counter tracks consecutive cycles of disagreement between the
   // synchronised level and the accepted level; any agreement restarts it.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sync1_d[i]    = btn_raw[i];
         sync2_d[i]    = sync1_q[i];
         deb_prev_d[i] = deb_q[i];
         deb_d[i]      = deb_q[i];
         cnt_d[i]      = 16'd0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = 16'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // Rising edge of the accepted level; release yields nothing.
   assign pulse   = deb_q & ~deb_prev_q;
   assign load_p  = pulse[0];
   assign clear_p = pulse[1];
   assign mode_p  = pulse[2];

   // FSM state register plus all other registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 3'd0;
         sync2_q    <= 3'd0;
         deb_q      <= 3'd0;
         deb_prev_q <= 3'd0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= 16'd0;
         end
         state_q    <= S_LOAD_X;
         x_q        <= 4'd0;
         y_q        <= 4'd0;
         select_q   <= 2'd0;
         valid_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         select_q   <= select_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state logic. Clear overrides load; the unused encoding falls
   // back to LOAD_X.
   always_comb begin
      state_d = state_q;
      if (clear_p) begin
         state_d = S_LOAD_X;
      end else begin
         case (state_q)
            S_LOAD_X: if (load_p) state_d = S_LOAD_Y;
            S_LOAD_Y: if (load_p) state_d = S_READY;
            S_READY:  if (load_p) state_d = S_LOAD_Y;
            default:  state_d = S_LOAD_X;
         endcase
      end
   end

   // Output/datapath logic. A load from READY starts a new pair: X is
   // replaced and Y keeps its stale value until the next load.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      valid_d  = (state_d == S_READY);
      select_d = select_q + {1'b0, mode_p};
      if (clear_p) begin
         x_d = 4'd0;
         y_d = 4'd0;
      end else if (load_p) begin
         case (state_q)
            S_LOAD_X: x_d = data_in;
            S_LOAD_Y: y_d = data_in;
            S_READY:  x_d = data_in;
            default:  x_d = x_q;
         endcase
      end
   end

   assign X              = x_q;
   assign Y              = y_q;
   assign select         = select_q;
   assign operands_valid = valid_q;
   assign state_out      = state_q;

endmodule
